// File: rtl/lookahead_alu_seq.sv
// Digit-serial lookahead ALU: DIGIT bits per clock, carry and group P/G carried between digits.
// Optional zero flag is built when LOOKAHEAD_ALU_SEQ_ZERO_EN is defined; otherwise zero is tied low.
module lookahead_alu_seq #(
    parameter int WIDTH = 16,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       s,
    input  logic             m,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             p_grp,
    output logic             g_grp,
    output logic             zero
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic [3:0]       s_reg;
    logic             m_reg;
    logic             c_reg;
    logic             g_acc_reg, p_acc_reg;
    logic [CW-1:0]    cnt_reg;
    logic [WIDTH-1:0] y_work_reg, y_reg;
    logic             cout_reg, p_grp_reg, g_grp_reg;

    logic [DIGIT-1:0] g_dig, t_dig, h_dig, y_dig;
    logic [DIGIT:0]   c_dig;
    logic             dig_g, dig_p;
    logic             g_acc_next, p_acc_next;
    logic [WIDTH-1:0] y_work_next;
    logic             last_dig;
    logic             accept;

    // Carry into bit idx+1 as a flat sum of products over bits 0..idx (no ripple).
    function automatic logic la_carry(input logic [DIGIT-1:0] g,
                                      input logic [DIGIT-1:0] t,
                                      input logic             c0,
                                      input int               idx);
        logic acc;
        logic pp;
        acc = 1'b0;
        pp  = 1'b1;
        for (int j = DIGIT - 1; j >= 0; j--) begin
            if (j <= idx) begin
                acc = acc | (pp & g[j]);
                pp  = pp & t[j];
            end
        end
        return acc | (pp & c0);
    endfunction

    // Operands are shifted right each cycle, so the active digit is always the low slice.
    genvar gi;
    generate
        for (gi = 0; gi < DIGIT; gi++) begin : g_bit
            assign g_dig[gi] = (a_reg[gi] & ~b_reg[gi] & s_reg[2]) |
                               (a_reg[gi] &  b_reg[gi] & s_reg[3]);
            assign t_dig[gi] = a_reg[gi] | (b_reg[gi] & s_reg[0]) | (~b_reg[gi] & s_reg[1]);
            assign h_dig[gi] = t_dig[gi] ^ g_dig[gi];
            assign c_dig[gi+1] = la_carry(g_dig, t_dig, c_reg, gi);
            assign y_dig[gi] = h_dig[gi] ^ (c_dig[gi] & ~m_reg);
        end

        if (DIGIT == WIDTH) begin : g_one_digit
            assign y_work_next = y_dig;
        end else begin : g_multi_digit
            assign y_work_next = {y_dig, y_work_reg[WIDTH-1:DIGIT]};
        end
    endgenerate

    assign c_dig[0]   = c_reg;
    assign dig_p      = &t_dig;
    assign dig_g      = la_carry(g_dig, t_dig, 1'b0, DIGIT - 1);
    assign g_acc_next = dig_g | (dig_p & g_acc_reg);
    assign p_acc_next = dig_p & p_acc_reg;
    assign last_dig   = (cnt_reg == CW'(N - 1));
    assign accept     = start & (state_reg != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last_dig) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg      <= '0;
            b_reg      <= '0;
            s_reg      <= '0;
            m_reg      <= 1'b0;
            c_reg      <= 1'b0;
            g_acc_reg  <= 1'b0;
            p_acc_reg  <= 1'b1;
            cnt_reg    <= '0;
            y_work_reg <= '0;
            y_reg      <= '0;
            cout_reg   <= 1'b0;
            p_grp_reg  <= 1'b0;
            g_grp_reg  <= 1'b0;
        end else if (accept) begin
            a_reg     <= a;
            b_reg     <= b;
            s_reg     <= s;
            m_reg     <= m;
            c_reg     <= cin;
            g_acc_reg <= 1'b0;
            p_acc_reg <= 1'b1;
            cnt_reg   <= '0;
        end else if (state_reg == RUN) begin
            a_reg      <= a_reg >> DIGIT;
            b_reg      <= b_reg >> DIGIT;
            c_reg      <= c_dig[DIGIT];
            g_acc_reg  <= g_acc_next;
            p_acc_reg  <= p_acc_next;
            cnt_reg    <= cnt_reg + 1'b1;
            y_work_reg <= y_work_next;
            // Visible outputs change only once the whole word is finished.
            if (last_dig) begin
                y_reg     <= y_work_next;
                cout_reg  <= c_dig[DIGIT] & ~m_reg;
                p_grp_reg <= p_acc_next;
                g_grp_reg <= g_acc_next;
            end
        end
    end

`ifdef LOOKAHEAD_ALU_SEQ_ZERO_EN
    logic z_acc_reg, zero_reg;
    logic z_acc_next;

    assign z_acc_next = z_acc_reg & ~(|y_dig);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z_acc_reg <= 1'b1;
            zero_reg  <= 1'b0;
        end else if (accept) begin
            z_acc_reg <= 1'b1;
        end else if (state_reg == RUN) begin
            z_acc_reg <= z_acc_next;
            if (last_dig) zero_reg <= z_acc_next;
        end
    end

    assign zero = zero_reg;
`else
    assign zero = 1'b0;
`endif

    assign busy  = (state_reg == RUN);
    assign done  = (state_reg == DONE);
    assign y     = y_reg;
    assign cout  = cout_reg;
    assign p_grp = p_grp_reg;
    assign g_grp = g_grp_reg;

endmodule

// File: tb/tb_lookahead_alu_seq.sv
// Scoreboard bench for lookahead_alu_seq (WIDTH=16, DIGIT=4): stimulus pushes expected
// results, a negedge monitor pops and compares whenever done is high.
module tb_lookahead_alu_seq;

    localparam int N = 4;
`ifdef LOOKAHEAD_ALU_SEQ_ZERO_EN
    localparam bit ZEN = 1'b1;
`else
    localparam bit ZEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [15:0] a, b;
    logic [3:0]  s;
    logic        m, cin;
    logic        busy, done;
    logic [15:0] y;
    logic        cout, p_grp, g_grp, zero;

    typedef struct {
        logic [15:0] y;
        logic        cout;
        logic        p;
        logic        g;
        logic        z;
        logic        chk_pg;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    lookahead_alu_seq #(.WIDTH(16), .DIGIT(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .s     (s),
        .m     (m),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .cout  (cout),
        .p_grp (p_grp),
        .g_grp (g_grp),
        .zero  (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s got=%h want=%h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (rst_n === 1'b1 && done === 1'b1) begin
            done_cnt++;
            $display("txn %0d: y=%h cout=%b p=%b g=%b zero=%b", done_cnt, y, cout, p_grp, g_grp, zero);
            if (exp_q.size() == 0) begin
                check("unexpected_done", 16'd1, 16'd0);
            end else begin
                e = exp_q.pop_front();
                check("y", y, e.y);
                check("cout", 16'(cout), 16'(e.cout));
                check("zero", 16'(zero), 16'(e.z));
                if (e.chk_pg) begin
                    check("p_grp", 16'(p_grp), 16'(e.p));
                    check("g_grp", 16'(g_grp), 16'(e.g));
                end
            end
        end
    end

    // Drive a request; one edge later it must be busy.
    task automatic issue(input logic [15:0] ia, input logic [15:0] ib, input logic [3:0] is,
                         input logic im, input logic icin, input bit push,
                         input logic [15:0] ey, input logic ec, input logic ep,
                         input logic eg, input logic ez, input bit chk_pg);
        a = ia; b = ib; s = is; m = im; cin = icin; start = 1'b1;
        if (push) exp_q.push_back(exp_t'{ey, ec, ep, eg, ez & ZEN, chk_pg});
        @(posedge clk); #1;
        start = 1'b0;
        a = ~ia; b = ~ib;
        check("busy_after_start", 16'(busy), 16'd1);
    endtask

    // Previous result must hold through RUN; done exactly N edges after accept.
    task automatic wait_done(input logic [15:0] prev_y);
        for (int k = 1; k <= N; k++) begin
            @(posedge clk); #1;
            if (k < N) begin
                check("done_early", 16'(done), 16'd0);
                check("y_hold", y, prev_y);
            end else begin
                check("done_at_N", 16'(done), 16'd1);
                check("busy_at_N", 16'(busy), 16'd0);
            end
        end
    endtask

    initial begin
        int saved;
        rst_n = 1'b0; start = 1'b0; a = '0; b = '0; s = '0; m = 1'b0; cin = 1'b0;
        #12;
        check("rst_y", y, 16'h0000);
        check("rst_flags", {10'd0, busy, done, cout, p_grp, g_grp, zero}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;

        // add
        issue(16'h1234, 16'h0FCD, 4'b1001, 1'b0, 1'b0, 1, 16'h2201, 0, 0, 0, 0, 1);
        wait_done(16'h0000);
        @(posedge clk); #1;
        // carry propagates through every digit
        issue(16'hFFFF, 16'h0001, 4'b1001, 1'b0, 1'b0, 1, 16'h0000, 1, 1, 1, 1, 1);
        wait_done(16'h2201);
        @(posedge clk); #1;
        // pure propagate with cin=1: P=1, G=0
        issue(16'hAAAA, 16'h5555, 4'b1001, 1'b0, 1'b1, 1, 16'h0000, 1, 1, 0, 1, 1);
        wait_done(16'h0000);
        @(posedge clk); #1;
        // subtract 5-7
        issue(16'h0005, 16'h0007, 4'b0110, 1'b0, 1'b1, 1, 16'hFFFE, 0, 0, 0, 0, 1);
        wait_done(16'h0000);
        @(posedge clk); #1;
        // logic xor, previous y must hold until done
        issue(16'hF0F0, 16'hFF00, 4'b1001, 1'b1, 1'b1, 1, 16'h0FF0, 0, 0, 0, 0, 0);
        wait_done(16'hFFFE);
        @(posedge clk); #1;

        // start during RUN is ignored
        issue(16'h00FF, 16'h0101, 4'b1001, 1'b0, 1'b0, 1, 16'h0200, 0, 0, 0, 0, 1);
        @(posedge clk); #1;
        a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("busy_ignored_start", 16'(busy), 16'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("done_ignored_case", 16'(done), 16'd1);
        @(posedge clk); #1;
        check("idle_after_ignored", 16'(busy), 16'd0);

        // back-to-back: start accepted in the DONE cycle
        issue(16'h8000, 16'h8000, 4'b1001, 1'b0, 1'b0, 1, 16'h0000, 1, 0, 1, 1, 1);
        wait_done(16'h0200);
        issue(16'h0010, 16'h0001, 4'b0110, 1'b0, 1'b1, 1, 16'h000F, 1, 0, 1, 0, 1);
        check("done_fell_b2b", 16'(done), 16'd0);
        wait_done(16'h0000);
        @(posedge clk); #1;

        // reset in cycle 2 of RUN aborts without done
        issue(16'h1111, 16'h1111, 4'b1001, 1'b0, 1'b0, 0, 16'h0, 0, 0, 0, 0, 0);
        @(posedge clk); #2;
        saved = done_cnt;
        rst_n = 1'b0;
        #1;
        check("abort_y", y, 16'h0000);
        check("abort_flags", {10'd0, busy, done, cout, p_grp, g_grp, zero}, 16'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        check("no_done_after_abort", 16'(done_cnt), 16'(saved));
        check("idle_after_abort", 16'(busy), 16'd0);
        issue(16'h7FFF, 16'h0001, 4'b1001, 1'b0, 1'b1, 1, 16'h8001, 0, 0, 0, 0, 1);
        wait_done(16'h0000);
        @(posedge clk); #1;

        check("queue_empty", 16'(exp_q.size()), 16'd0);
        check("done_count", 16'(done_cnt), 16'd9);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
